conv_scan_sequencer: RTL and testbench

//  Sequences the MAC datapath over a 3-level nested scan: cnt0 innermost, cnt2 outermost.

---
 rtl/conv_ctrl_pkg.sv | 18 +
 rtl/wrap_counter.sv | 33 +++
 rtl/conv_scan_sequencer.sv | 134 +++++++++++++
 tb/tb_conv_scan_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// ============================================================================
// conv_ctrl_pkg : shared state encoding for the convolution scan control path
// Revision      : 1.0
// ============================================================================
`default_nettype none

package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wrap_counter.sv
// ============================================================================
// wrap_counter : loop index counting 0..lim inclusive, flags the last value
// Revision     : 1.0
// ============================================================================
`default_nettype none

module wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] lim,
    output logic [W-1:0] q,
    output logic         wrap
);

    assign wrap = (q == lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= wrap ? '0 : q + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_scan_sequencer.sv
// ============================================================================
// conv_scan_sequencer : 3-level nested scan sequencer driving the MAC datapath
// Revision            : 1.0
// ============================================================================
`default_nettype none

module conv_scan_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int C0_W = 4,
    parameter int C1_W = 4,
    parameter int C2_W = 6,
    parameter int SC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [C0_W-1:0] lim0,
    input  logic [C1_W-1:0] lim1,
    input  logic [C2_W-1:0] lim2,
    input  logic            in_valid,
    input  logic            out_ready,
    output logic            in_ready,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            acc_first,
    output logic            res_ld,
    output logic [C0_W-1:0] cnt0,
    output logic [C1_W-1:0] cnt1,
    output logic [C2_W-1:0] cnt2,
    output logic            busy,
    output logic            done,
    output logic [SC_W-1:0] stall_cnt
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [C0_W-1:0] r_lim0;
    logic [C1_W-1:0] r_lim1;
    logic [C2_W-1:0] r_lim2;
    logic            w_load;
    logic            w_step;
    logic            w_wrap0;
    logic            w_wrap1;
    logic            w_wrap2;
    logic            w_last;

    assign w_load = (r_state == ST_LOAD);
    assign w_step = (r_state == ST_RUN) & in_valid & out_ready;
    assign w_last = w_step & w_wrap0 & w_wrap1 & w_wrap2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Limits are captured once per scan so mid-scan input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lim0 <= '0;
            r_lim1 <= '0;
            r_lim2 <= '0;
        end else if (w_load) begin
            r_lim0 <= lim0;
            r_lim1 <= lim1;
            r_lim2 <= lim2;
        end
    end

    wrap_counter #(.W(C0_W)) u_cnt0 (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_load),
        .inc  (w_step),
        .lim  (r_lim0),
        .q    (cnt0),
        .wrap (w_wrap0)
    );

    wrap_counter #(.W(C1_W)) u_cnt1 (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_load),
        .inc  (w_step & w_wrap0),
        .lim  (r_lim1),
        .q    (cnt1),
        .wrap (w_wrap1)
    );

    wrap_counter #(.W(C2_W)) u_cnt2 (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_load),
        .inc  (w_step & w_wrap0 & w_wrap1),
        .lim  (r_lim2),
        .q    (cnt2),
        .wrap (w_wrap2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (w_load) begin
            stall_cnt <= '0;
        end else if ((r_state == ST_RUN) && !w_step && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + SC_W'(1);
        end
    end

    assign in_ready  = w_step;
    assign acc_en    = w_step;
    assign acc_first = w_step & (cnt0 == '0) & (cnt1 == '0);
    assign res_ld    = w_step & w_wrap0 & w_wrap1;
    assign acc_clr   = w_load;
    assign busy      = w_load | (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_conv_scan_sequencer.sv
// ============================================================================
// tb_conv_scan_sequencer : randomized self-checking bench with nested-loop model
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_conv_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] lim0;
    logic [3:0] lim1;
    logic [5:0] lim2;
    logic       in_valid;
    logic       out_ready;
    logic       in_ready;
    logic       acc_clr;
    logic       acc_en;
    logic       acc_first;
    logic       res_ld;
    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic [5:0] cnt2;
    logic       busy;
    logic       done;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_scan_sequencer #(.C0_W(4), .C1_W(4), .C2_W(6), .SC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lim0      (lim0),
        .lim1      (lim1),
        .lim2      (lim2),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .acc_first (acc_first),
        .res_ld    (res_ld),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [10:0] outs_vec();
        return {in_ready, acc_clr, acc_en, acc_first, res_ld, busy, done,
                (cnt0 != 0), (cnt1 != 0), (cnt2 != 0), (stall_cnt != 0)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; lim0 = 4'd3; lim1 = 4'd3; lim2 = 6'd3;
        in_valid = 1'b1; out_ready = 1'b1;
        #12;
        checks++;
        if (outs_vec() !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: outputs %b, want all zero", outs_vec());
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (outs_vec() !== 11'd0) begin
            errors++;
            $display("FAIL reset_idle: outputs %b, want all zero", outs_vec());
        end
    endtask

    task automatic do_start(input int l0, input int l1, input int l2);
        @(negedge clk);
        start = 1'b1; lim0 = 4'(l0); lim1 = 4'(l1); lim2 = 6'(l2);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (!(busy === 1'b1 && acc_clr === 1'b1 && done === 1'b0 && in_ready === 1'b0)) begin
            errors++;
            $display("FAIL load_cycle: busy=%b acc_clr=%b done=%b in_ready=%b, want 1 1 0 0",
                     busy, acc_clr, done, in_ready);
        end
    endtask

    // mode 0: always ready; 1: random; 2: in_valid low for run index lo..hi; 3: out_ready low lo..hi
    task automatic run_scan(input int l0, input int l1, input int l2, input int mode,
                            input int lo, input int hi, input bit chaos,
                            output int done_idx, output int stalls);
        int q0[$]; int q1[$]; int q2[$];
        int est = 0;
        int idx = 0;
        int pops = 0;
        int nres = 0;
        bit fin = 1'b0;
        bit iv, orr, stp;
        done_idx = -1;
        for (int c2 = 0; c2 <= l2; c2++)
            for (int c1 = 0; c1 <= l1; c1++)
                for (int c0 = 0; c0 <= l0; c0++) begin
                    q0.push_back(c0); q1.push_back(c1); q2.push_back(c2);
                end
        do_start(l0, l1, l2);
        while (!fin && idx < 5000) begin
            @(negedge clk);
            case (mode)
                0: begin iv = 1'b1; orr = 1'b1; end
                1: begin iv = ($urandom_range(0, 3) != 0); orr = ($urandom_range(0, 3) != 0); end
                2: begin iv = !(idx >= lo && idx <= hi); orr = 1'b1; end
                default: begin iv = 1'b1; orr = !(idx >= lo && idx <= hi); end
            endcase
            in_valid = iv; out_ready = orr;
            if (chaos) begin
                start = 1'($urandom); lim0 = 4'($urandom); lim1 = 4'($urandom); lim2 = 6'($urandom);
            end
            if (q0.size() == 0) start = 1'b0;
            #1;
            pops += int'(in_ready);
            nres += int'(res_ld);
            if (q0.size() == 0) begin
                checks++;
                if (!(done === 1'b1 && busy === 1'b0 && in_ready === 1'b0 && res_ld === 1'b0 &&
                      cnt0 === 4'd0 && cnt1 === 4'd0 && cnt2 === 6'd0 && stall_cnt === 16'(est))) begin
                    errors++;
                    $display("FAIL done_cycle: done=%b busy=%b pop=%b res=%b cnt=%0d/%0d/%0d stall=%0d, want 1 0 0 0 0/0/0 %0d",
                             done, busy, in_ready, res_ld, cnt0, cnt1, cnt2, stall_cnt, est);
                end
                done_idx = idx;
                fin = 1'b1;
            end else begin
                stp = iv & orr;
                checks++;
                if (!(busy === 1'b1 && done === 1'b0 && acc_clr === 1'b0 &&
                      in_ready === stp && acc_en === stp)) begin
                    errors++;
                    $display("FAIL run_flags idx %0d: busy=%b done=%b clr=%b pop=%b en=%b, want 1 0 0 %b %b",
                             idx, busy, done, acc_clr, in_ready, acc_en, stp, stp);
                end
                checks++;
                if (!(cnt0 === 4'(q0[0]) && cnt1 === 4'(q1[0]) && cnt2 === 6'(q2[0]) &&
                      stall_cnt === 16'(est))) begin
                    errors++;
                    $display("FAIL run_index idx %0d: cnt=%0d/%0d/%0d stall=%0d, want %0d/%0d/%0d %0d",
                             idx, cnt0, cnt1, cnt2, stall_cnt, q0[0], q1[0], q2[0], est);
                end
                checks++;
                if (stp) begin
                    if (!(acc_first === (q0[0] == 0 && q1[0] == 0) &&
                          res_ld === (q0[0] == l0 && q1[0] == l1))) begin
                        errors++;
                        $display("FAIL step_strobes idx %0d: first=%b res=%b, want %b %b",
                                 idx, acc_first, res_ld, (q0[0] == 0 && q1[0] == 0),
                                 (q0[0] == l0 && q1[0] == l1));
                    end
                    void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
                end else begin
                    if (!(acc_first === 1'b0 && res_ld === 1'b0)) begin
                        errors++;
                        $display("FAIL stall_strobes idx %0d: first=%b res=%b, want 0 0",
                                 idx, acc_first, res_ld);
                    end
                    if (est < 65535) est++;
                end
            end
            idx++;
        end
        start = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL scan_timeout: no done after %0d cycles, want done", idx);
        end
        checks++;
        if (pops != (l0 + 1) * (l1 + 1) * (l2 + 1) || nres != l2 + 1) begin
            errors++;
            $display("FAIL scan_totals: pops=%0d res_ld=%0d, want %0d %0d",
                     pops, nres, (l0 + 1) * (l1 + 1) * (l2 + 1), l2 + 1);
        end
        @(negedge clk); #1;
        checks++;
        if (!(done === 1'b0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL back_to_idle: done=%b busy=%b, want 0 0", done, busy);
        end
        stalls = est;
    endtask

    task automatic test_basic();
        int di, st;
        run_scan(1, 1, 1, 0, 0, 0, 1'b0, di, st);
        checks++;
        if (di != 8) begin
            errors++;
            $display("FAIL basic_done_time: done at run cycle %0d, want 8", di);
        end
    endtask

    task automatic test_zero_limits();
        int di, st;
        run_scan(0, 0, 0, 0, 0, 0, 1'b0, di, st);
        checks++;
        if (di != 1) begin
            errors++;
            $display("FAIL zero_done_time: done at run cycle %0d, want 1", di);
        end
    endtask

    task automatic test_fifo_empty();
        int di, st;
        run_scan(2, 0, 0, 2, 1, 3, 1'b0, di, st);
        checks++;
        if (di != 6 || st != 3) begin
            errors++;
            $display("FAIL empty_stall: done at %0d stalls %0d, want 6 3", di, st);
        end
    endtask

    task automatic test_out_stall();
        int di, st;
        run_scan(1, 1, 0, 3, 3, 4, 1'b0, di, st);
        checks++;
        if (di != 6 || st != 2) begin
            errors++;
            $display("FAIL out_stall: done at %0d stalls %0d, want 6 2", di, st);
        end
    endtask

    task automatic test_mid_reset();
        int di, st;
        bit found = 1'b0;
        do_start(2, 2, 1);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; #1;
            if (cnt0 == 4'd1 && cnt1 == 4'd1 && cnt2 == 6'd0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_reach: cnt=%0d/%0d/%0d, want 1/1/0", cnt0, cnt1, cnt2);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs_vec() !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: outputs %b, want all zero", outs_vec());
        end
        #2; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_idle: done=%b busy=%b, want 0 0", done, busy);
            end
        end
        run_scan(1, 2, 0, 0, 0, 0, 1'b0, di, st);
    endtask

    task automatic test_random_scans();
        int di, st;
        for (int n = 0; n < 8; n++) begin
            run_scan(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), 1, 0, 0, 1'b1, di, st);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_limits();
        test_fifo_empty();
        test_out_stall();
        test_mid_reset();
        test_random_scans();
        test_basic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
